// File: rtl/water_supply_level_counter_pkg.sv
// Shared types and constants for the water supply level tracker.
package water_supply_pkg;

    localparam int unsigned LEVEL_W = 3;
    localparam logic [LEVEL_W-1:0] LEVEL_FULL  = 3'b000;
    localparam logic [LEVEL_W-1:0] LEVEL_EMPTY = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_EMPTY  = 2'd2,
        ST_REFILL = 2'd3
    } state_t;

endpackage

// File: rtl/water_supply_level_counter_if.sv
// Controller-to-tank-tracker signal bundle.
interface water_supply_level_counter_if;
    import water_supply_pkg::*;

    logic               irrigating;
    logic               refill_req;
    logic [LEVEL_W-1:0] water_level;
    logic               tank_full;
    logic               tank_empty;
    logic               refilling;
    logic               irrigation_enable;
    logic               level_changed;

    // Irrigation controller / display side
    modport master (
        output irrigating, refill_req,
        input  water_level, tank_full, tank_empty, refilling,
               irrigation_enable, level_changed
    );

    // Level tracker side
    modport slave (
        input  irrigating, refill_req,
        output water_level, tank_full, tank_empty, refilling,
               irrigation_enable, level_changed
    );
endinterface

// File: rtl/water_supply_level_counter_step_timer.sv
// Step timer: counts enabled cycles and strobes when the terminal count is hit.
module water_step_timer #(
    parameter int unsigned CNT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_tc,
    output logic             o_step_c
);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles; clear wins over enable, wrap to zero at terminal count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            if (r_count == i_tc) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_step_c = i_en && !i_clear && (r_count == i_tc);

endmodule

// File: rtl/water_supply_level_counter.sv
// Irrigation tank level tracker: drains while irrigating, refills on request.
module water_supply_level_counter
    import water_supply_pkg::*;
#(
    parameter int unsigned DRAIN_TICKS = 50_000_000,
    parameter int unsigned FILL_TICKS  = 25_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    water_supply_level_counter_if.slave   bus
);

    localparam int unsigned MAX_TICKS = (DRAIN_TICKS > FILL_TICKS) ? DRAIN_TICKS : FILL_TICKS;
    localparam int unsigned CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    state_t             r_state;
    logic [LEVEL_W-1:0] r_level;
    logic               r_level_changed;

    logic               w_refill_go;
    logic               w_tmr_en;
    logic               w_tmr_clear;
    logic [CNT_W-1:0]   w_tmr_tc;
    logic               w_step;
    logic [LEVEL_W-1:0] w_level_inc;
    logic [LEVEL_W-1:0] w_level_dec;

    // A refill request at full is meaningless and ignored in every state
    assign w_refill_go = bus.refill_req && (r_level != LEVEL_FULL);
    assign w_level_inc = r_level + LEVEL_W'(1);
    assign w_level_dec = r_level - LEVEL_W'(1);

    // Timer control: drain counting accumulates across IDLE/DRAIN, refill counts every cycle
    always_comb begin
        w_tmr_en    = 1'b0;
        w_tmr_clear = 1'b0;
        w_tmr_tc    = CNT_W'(DRAIN_TICKS - 1);
        case (r_state)
            ST_IDLE, ST_DRAIN: begin
                w_tmr_clear = w_refill_go;
                w_tmr_en    = bus.irrigating && !w_refill_go;
            end
            ST_EMPTY: begin
                w_tmr_clear = w_refill_go;
            end
            ST_REFILL: begin
                w_tmr_en = 1'b1;
                w_tmr_tc = CNT_W'(FILL_TICKS - 1);
            end
            default: ;
        endcase
    end

    water_step_timer #(
        .CNT_W (CNT_W)
    ) u_step_timer (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_tmr_en),
        .i_clear  (w_tmr_clear),
        .i_tc     (w_tmr_tc),
        .o_step_c (w_step)
    );

    // Tank FSM: level steps and state transitions on timer strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_level         <= LEVEL_FULL;
            r_level_changed <= 1'b0;
        end else begin
            r_level_changed <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DRAIN: begin
                    if (w_refill_go) begin
                        r_state <= ST_REFILL;
                    end else if (!bus.irrigating) begin
                        r_state <= ST_IDLE;
                    end else if (w_step) begin
                        r_level         <= w_level_inc;
                        r_level_changed <= 1'b1;
                        r_state         <= (w_level_inc == LEVEL_EMPTY) ? ST_EMPTY : ST_DRAIN;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_EMPTY: begin
                    if (w_refill_go) begin
                        r_state <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (w_step) begin
                        r_level         <= w_level_dec;
                        r_level_changed <= 1'b1;
                        if (w_level_dec == LEVEL_FULL) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output decode from registered state and level only
    assign bus.water_level       = r_level;
    assign bus.tank_full         = (r_level == LEVEL_FULL);
    assign bus.tank_empty        = (r_level == LEVEL_EMPTY);
    assign bus.refilling         = (r_state == ST_REFILL);
    assign bus.irrigation_enable = (r_state == ST_IDLE) || (r_state == ST_DRAIN);
    assign bus.level_changed     = r_level_changed;

endmodule

// File: tb/tb_water_supply_level_counter.sv
// Bench for the tank level tracker: vector table, directed corner sequences, random vs model.
module tb_water_supply_level_counter;

    localparam int unsigned D = 4;
    localparam int unsigned F = 2;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic reset  = 1'b0;

    int total = 0;
    int bad   = 0;

    // Reference model state: integer level 0..7, drain accumulation, refill progress
    int m_level = 0;
    int m_acc   = 0;
    int m_rcnt  = 0;
    int m_rf    = 0;
    int m_chg   = 0;

    typedef struct {
        int   reps;
        logic irr;
        logic rr;
        int   lvl;
        int   chg;
        int   rf;
    } vec_t;

    vec_t tbl[$];

    water_supply_level_counter_if bus();

    water_supply_level_counter #(
        .DRAIN_TICKS (D),
        .FILL_TICKS  (F)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Gated clock so reset can be checked with no edges at all
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input int lvl, input int chg, input int rf);
        chk({name, ".water_level"},       int'(bus.water_level),       lvl);
        chk({name, ".tank_full"},         int'(bus.tank_full),         (lvl == 0) ? 1 : 0);
        chk({name, ".tank_empty"},        int'(bus.tank_empty),        (lvl == 7) ? 1 : 0);
        chk({name, ".refilling"},         int'(bus.refilling),         rf);
        chk({name, ".irrigation_enable"}, int'(bus.irrigation_enable), (rf == 0 && lvl != 7) ? 1 : 0);
        chk({name, ".level_changed"},     int'(bus.level_changed),     chg);
    endtask

    // Apply inputs for one rising edge; return 1 ns after it
    task automatic edge1(input logic irr, input logic rr);
        bus.irrigating = irr;
        bus.refill_req = rr;
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges and release it before the next one
    task automatic do_reset();
        bus.irrigating = 1'b0;
        bus.refill_req = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        m_level = 0; m_acc = 0; m_rcnt = 0; m_rf = 0; m_chg = 0;
    endtask

    // Behavioural tank: cumulative irrigation cycles drain, timed refill restores
    task automatic model_step(input logic irr, input logic rr);
        m_chg = 0;
        if (m_rf != 0) begin
            m_rcnt++;
            if (m_rcnt == int'(F)) begin
                m_rcnt  = 0;
                m_level = m_level - 1;
                m_chg   = 1;
                if (m_level == 0) m_rf = 0;
            end
        end else if (rr && m_level != 0) begin
            m_rf   = 1;
            m_rcnt = 0;
            m_acc  = 0;
        end else if (irr && m_level != 7) begin
            m_acc++;
            if (m_acc == int'(D)) begin
                m_acc   = 0;
                m_level = m_level + 1;
                m_chg   = 1;
            end
        end
    endtask

    initial begin
        bus.irrigating = 1'b0;
        bus.refill_req = 1'b0;

        // Reset with no clock running
        reset = 1'b1;
        #5;
        chk_outs("reset_noclk", 0, 0, 0);
        #2;
        reset  = 1'b0;
        clk_en = 1'b1;
        edge1(1'b0, 1'b0);
        chk_outs("idle_after_reset", 0, 0, 0);

        // Vector table: partial drain accumulation, refill priority, refill at full
        tbl.push_back('{3,  1'b1, 1'b0, 0, 0, 0});
        tbl.push_back('{10, 1'b0, 1'b0, 0, 0, 0});
        tbl.push_back('{1,  1'b1, 1'b0, 1, 1, 0});
        tbl.push_back('{3,  1'b1, 1'b0, 1, 0, 0});
        tbl.push_back('{1,  1'b1, 1'b0, 2, 1, 0});
        tbl.push_back('{4,  1'b1, 1'b0, 3, 1, 0});
        tbl.push_back('{2,  1'b1, 1'b0, 3, 0, 0});
        tbl.push_back('{1,  1'b1, 1'b1, 3, 0, 1});
        tbl.push_back('{1,  1'b0, 1'b0, 3, 0, 1});
        tbl.push_back('{1,  1'b0, 1'b0, 2, 1, 1});
        tbl.push_back('{2,  1'b1, 1'b1, 1, 1, 1});
        tbl.push_back('{1,  1'b0, 1'b0, 1, 0, 1});
        tbl.push_back('{1,  1'b0, 1'b0, 0, 1, 0});
        tbl.push_back('{1,  1'b0, 1'b1, 0, 0, 0});
        tbl.push_back('{1,  1'b1, 1'b1, 0, 0, 0});
        for (int i = 0; i < tbl.size(); i++) begin
            repeat (tbl[i].reps) edge1(tbl[i].irr, tbl[i].rr);
            chk_outs($sformatf("tbl%0d", i), tbl[i].lvl, tbl[i].chg, tbl[i].rf);
        end

        // Full drain to empty, then irrigation has no further effect
        do_reset();
        for (int k = 1; k <= 36; k++) begin
            edge1(1'b1, 1'b0);
            chk_outs($sformatf("drain%0d", k), (k >= 28) ? 7 : k / 4,
                     (k <= 28 && k % 4 == 0) ? 1 : 0, 0);
        end

        // Refill from empty back to full
        edge1(1'b0, 1'b1);
        chk_outs("refill_enter", 7, 0, 1);
        for (int k = 1; k <= 14; k++) begin
            edge1(1'b0, 1'b0);
            chk_outs($sformatf("refill%0d", k), 7 - k / 2, (k % 2 == 0) ? 1 : 0,
                     (k < 14) ? 1 : 0);
        end

        // Async reset mid-refill at level 100, then refill request at full is ignored
        repeat (28) edge1(1'b1, 1'b0);
        edge1(1'b0, 1'b1);
        repeat (6) edge1(1'b0, 1'b0);
        chk_outs("mid_refill_l4", 4, 1, 1);
        edge1(1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk_outs("async_reset", 0, 0, 0);
        reset = 1'b0;
        edge1(1'b0, 1'b1);
        chk_outs("rr_at_full", 0, 0, 0);
        edge1(1'b0, 1'b0);
        chk_outs("rr_at_full_after", 0, 0, 0);

        // Randomized traffic against the behavioural model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic irr;
            logic rr;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                chk_outs("rand_reset", 0, 0, 0);
            end
            irr = ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 63) == 0);
            edge1(irr, rr);
            model_step(irr, rr);
            chk_outs($sformatf("rand%0d", n), m_level, m_chg, m_rf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/water_supply_level_counter.md
Name: water_supply_level_counter

Overview:
Tracks the irrigation tank's water level as a 3-bit code. The level counts down (fills) or up (drains) on timed steps. Produces the `water_level` code consumed by the LED-matrix tank decoder: 000 = full, 111 = empty. Also gates the irrigation valves when the tank is empty or refilling. Sits between the irrigation controller (`irrigating`, `refill_req`) and the matrix display path.

Parameters:
DRAIN_TICKS, 50_000_000, clock cycles of active irrigation per one-level drop; must be >= 1.
FILL_TICKS, 25_000_000, clock cycles of refilling per one-level rise; must be >= 1.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
irrigating  input  1  level, high while valves consume water.
refill_req  input  1  request to start refilling (pulse or level).
water_level  output  3  encoded level: 000 full … 111 empty.
tank_full  output  1  high when water_level == 000.
tank_empty  output  1  high when water_level == 111.
refilling  output  1  high while in REFILL.
irrigation_enable  output  1  low in EMPTY and REFILL, high otherwise.
level_changed  output  1  one-cycle pulse on the edge where water_level changes.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- On reset assertion, with no clock needed:
  - state = IDLE, water_level = 000, step counter = 0.
  - tank_full = 1, tank_empty = 0, refilling = 0, irrigation_enable = 1, level_changed = 0.
- All outputs are decoded from registered state and level only. There is no combinational path from any input to any output.
- Step counter width is clog2(max(DRAIN_TICKS, FILL_TICKS)).
- States: IDLE, DRAIN, EMPTY, REFILL.
- IDLE:
  - refill_req=1 and level != 000 -> REFILL, counter cleared.
  - Otherwise irrigating=1 -> DRAIN, and the counter increments on this same edge.
  - refill_req at full is ignored.
- DRAIN:
  - Counter increments on each edge with irrigating=1.
  - irrigating=0 -> IDLE. The counter holds, so partial consumption accumulates.
  - When counter == DRAIN_TICKS-1 on an irrigating edge: counter -> 0, level +1, level_changed = 1.
  - If the new level is 111 -> EMPTY.
  - refill_req=1 has priority over irrigating: -> REFILL, counter cleared, no level change on that edge.
- EMPTY:
  - Level holds at 111. irrigating is ignored.
  - refill_req=1 -> REFILL, counter cleared.
- REFILL:
  - Counter increments every edge.
  - When counter == FILL_TICKS-1: counter -> 0, level -1, level_changed = 1.
  - If the new level is 000 -> IDLE on the same edge.
  - irrigating and refill_req are ignored.
- Latency:
  - First drop occurs on the DRAIN_TICKS-th cumulative irrigating edge.
  - Each rise occurs FILL_TICKS edges after entering REFILL or after the previous rise.
- Level arithmetic saturates:
  - Never increments past 111; DRAIN is left on reaching it.
  - Never decrements past 000; REFILL is left on reaching it.
  - No wrap-around.
- With DRAIN_TICKS = 1 or FILL_TICKS = 1, the level steps every qualifying edge.
- Reset mid-operation aborts any drain or refill immediately and returns to the full/IDLE values.

Decomposition:
- Package water_supply_pkg:
  - state typedef (IDLE, DRAIN, EMPTY, REFILL).
  - LEVEL_W = 3, LEVEL_FULL = 3'b000, LEVEL_EMPTY = 3'b111.
- One sub-module, water_step_timer:
  - Parameterised-width counter with enable, synchronous clear and a terminal-count input (DRAIN_TICKS-1 or FILL_TICKS-1 selected by the FSM).
  - Outputs a one-cycle step strobe.
  - Uses the same async reset.

Test Plan:
All scenarios use DRAIN_TICKS=4, FILL_TICKS=2.
1. Assert reset with no clock -> water_level=000, tank_full=1, tank_empty=0, irrigation_enable=1, refilling=0.
2. Hold irrigating=1 for 28 edges -> level steps 001…111 on edges 4, 8, …, 28, with level_changed pulsing each time; at edge 28 tank_empty=1 and irrigation_enable=0. Another 8 edges of irrigating -> level stays 111.
3. irrigating=1 for 3 edges, 0 for 10, then 1 for 1 edge -> water_level changes 000->001 only on that 4th cumulative irrigating edge.
4. From EMPTY, pulse refill_req -> refilling=1, irrigation_enable=0, level decrements every 2 edges; after 14 edges level=000, tank_full=1, refilling=0, irrigation_enable=1.
5. At level 011 in DRAIN with counter=2, assert irrigating and refill_req together -> REFILL entered, level stays 011 on that edge, next change is 010 two edges later.
6. At level 100 mid-REFILL, assert reset between clock edges -> outputs return to reset values immediately. After release, refill_req at level 000 is ignored (refilling stays 0).
